// File: rtl/ps2_pkg.sv
// Shared PS/2 link-layer definitions.
// Used by the byte receiver and the host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS       = 8;
  localparam int PS2_FRAME_BITS      = 11;
  localparam int PS2_TIMEOUT_DEFAULT = 10000;

endpackage

// File: rtl/ps2_byte_receiver_if.sv
// Byte delivery bundle from the PS/2 receiver
// to the mouse packet decoder.
interface ps2_byte_receiver_if;

  logic [7:0] received_data;
  logic       received_data_en;
  logic       frame_error;

  modport master (
    output received_data,
    output received_data_en,
    output frame_error
  );

  modport slave (
    input received_data,
    input received_data_en,
    input frame_error
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Multi-flop synchroniser with registered falling-edge detect.
// level_o is the synchronised level aligned with fe_o.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fe_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic [STAGES-1:0] flush_q, flush_d;
  logic              prev_q, prev_d;
  logic              arm_q, arm_d;
  logic              fe_q, fe_d;
  logic              cur;

  // Edges are armed only once a real high has crossed the chain,
  // so a line held low through reset never looks like a fall.
  always_comb begin
    cur     = sync_q[STAGES-1];
    sync_d  = {sync_q[STAGES-2:0], line_i};
    flush_d = {flush_q[STAGES-2:0], 1'b1};
    prev_d  = cur;
    arm_d   = arm_q | (flush_q[STAGES-1] & cur);
    fe_d    = arm_q & prev_q & ~cur;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '1;
      flush_q <= '0;
      prev_q  <= 1'b1;
      arm_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      flush_q <= flush_d;
      prev_q  <= prev_d;
      arm_q   <= arm_d;
      fe_q    <= fe_d;
    end
  end

  assign level_o = prev_q;
  assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_byte_receiver.sv
// Receive-only PS/2 deframer: start, 8 data LSB-first,
// odd parity, stop; one-cycle strobes for bytes and errors.
module ps2_byte_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic PS2_CLK,
  input  logic PS2_DAT,
  ps2_byte_receiver_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_DATA   = ST_DATA;
  localparam logic [1:0] S_PARITY = ST_PARITY;
  localparam logic [1:0] S_STOP   = ST_STOP;

  logic fe, bit_s;
  logic clk_lvl_unused, dat_fe_unused;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clock   (clock),
    .reset   (reset),
    .line_i  (PS2_CLK),
    .level_o (clk_lvl_unused),
    .fe_o    (fe)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
    .clock   (clock),
    .reset   (reset),
    .line_i  (PS2_DAT),
    .level_o (bit_s),
    .fe_o    (dat_fe_unused)
  );

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    en_d      = 1'b0;
    err_d     = 1'b0;
    tmo_hit   = (state_q != S_IDLE) && (tmo_q == TMO_MAX);

    if (state_q == S_IDLE || fe || tmo_hit)
      tmo_d = '0;
    else if (tmo_q != TMO_MAX)
      tmo_d = tmo_q + 1'b1;
    else
      tmo_d = tmo_q;

    // A stalled frame wins over an edge landing in the same cycle.
    if (tmo_hit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      err_d     = 1'b1;
    end else if (fe) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bit_s) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        S_DATA: begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT)
            state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = bit_s;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (bit_s && (^{shift_q, par_q})) begin
            data_d = shift_q;
            en_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      en_q      <= en_d;
      err_q     <= err_d;
    end
  end

  assign rx.received_data    = data_q;
  assign rx.received_data_en = en_q;
  assign rx.frame_error      = err_q;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Directed and randomized frame bench for ps2_byte_receiver
// against a frame-level model of good/bad bytes.
module tb_ps2_byte_receiver;

  localparam int T = 200;
  localparam int S = 2;
  localparam int H = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_byte_receiver_if rx_if();

  ps2_byte_receiver #(
    .TIMEOUT_CYCLES (T),
    .SYNC_STAGES    (S)
  ) dut (
    .clock   (clk),
    .reset   (reset),
    .PS2_CLK (ps2c),
    .PS2_DAT (ps2d),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int en_cnt = 0, err_cnt = 0, both_cnt = 0;
  int en_cyc = 0, err_cyc = 0, fall_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rx_if.received_data_en) begin
      en_cnt++;
      en_cyc = cyc;
      got_q.push_back(rx_if.received_data);
    end
    if (rx_if.frame_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rx_if.received_data_en && rx_if.frame_error)
      both_cnt++;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: a frame is good when start=0, stop=1 and the nine
  // data+parity bits hold an odd number of ones.
  function automatic bit frame_good(input logic [10:0] f);
    logic [8:0] dp;
    dp = f[9:1];
    return (f[0] == 1'b0) && (f[10] == 1'b1)
        && (($countones(dp) % 2) == 1);
  endfunction

  function automatic logic [10:0] mk(input logic [7:0] b,
                                    input bit par_ok,
                                    input bit stop);
    int ones;
    logic par;
    ones = $countones(b);
    par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    if (!par_ok) par = ~par;
    return {stop ? 1'b1 : 1'b0, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0;
      fall_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
    end
  endtask

  task automatic frame(input logic [10:0] f, input string tag);
    int e0, r0;
    bit good;
    e0 = en_cnt;
    r0 = err_cnt;
    send_bits(f, 11);
    ps2d = 1'b1;
    repeat (2 * H) @(negedge clk);
    good = frame_good(f);
    if (good) begin
      exp_data = f[8:1];
      exp_q.push_back(f[8:1]);
    end
    chk({tag, "_en"}, en_cnt - e0, good ? 1 : 0);
    chk({tag, "_err"}, err_cnt - r0, good ? 0 : 1);
    chk({tag, "_data"}, int'(rx_if.received_data), int'(exp_data));
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int e0, r0;
    logic [7:0] b;
    int kind;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", int'(rx_if.received_data), 0);
    chk("rst_en", int'(rx_if.received_data_en), 0);
    chk("rst_err", int'(rx_if.frame_error), 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    frame(mk(8'hFA, 1, 1), "fa");
    chk("fa_latency", en_cyc - fall_cyc, S + 2);

    frame(mk(8'h08, 1, 1), "b2b_08");
    frame(mk(8'h05, 1, 1), "b2b_05");
    frame(mk(8'hFE, 1, 1), "b2b_fe");

    frame(mk(8'h08, 0, 1), "par_err");
    chk("err_latency", err_cyc - fall_cyc, S + 2);

    e0 = en_cnt;
    r0 = err_cnt;
    send_bits(mk(8'h5C, 1, 1), 5);
    repeat (T - 40) @(negedge clk);
    chk("tmo_early", err_cnt - r0, 0);
    repeat (80) @(negedge clk);
    chk("tmo_err", err_cnt - r0, 1);
    chk("tmo_en", en_cnt - e0, 0);
    frame(mk(8'h00, 1, 1), "after_tmo");

    e0 = en_cnt;
    r0 = err_cnt;
    send_bits(mk(8'h3C, 1, 1), 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_data = 8'h00;
    chk("midrst_data", int'(rx_if.received_data), 0);
    chk("midrst_en_o", int'(rx_if.received_data_en), 0);
    chk("midrst_err_o", int'(rx_if.frame_error), 0);
    repeat (2 * H) @(negedge clk);
    chk("midrst_en", en_cnt - e0, 0);
    chk("midrst_err", err_cnt - r0, 0);
    frame(mk(8'hAA, 1, 1), "after_rst");

    e0 = en_cnt;
    r0 = err_cnt;
    ps2c = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_data = 8'h00;
    repeat (60) @(negedge clk);
    chk("glitch_en", en_cnt - e0, 0);
    chk("glitch_err", err_cnt - r0, 0);
    ps2c = 1'b1;
    repeat (H) @(negedge clk);
    frame(mk(8'h5A, 1, 1), "after_glitch");

    e0 = en_cnt;
    r0 = err_cnt;
    send_bits(11'h7FF, 1);
    repeat (2 * H) @(negedge clk);
    chk("bad_start_err", err_cnt - r0, 1);
    chk("bad_start_en", en_cnt - e0, 0);

    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 3);
      frame(mk(b, kind != 2, kind != 3), $sformatf("rnd%0d", i));
    end

    chk("mutex", both_cnt, 0);
    chk("byte_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("byte%0d", i), int'(got_q[i]), int'(exp_q[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
